// File: rtl/serial_frame_tx.sv
// Bit-serial frame transmitter: 0x55 preamble, sync word, streamed payload bytes, zero tail.
// Advances one bit per bit_tick and enables the tick generator only while a frame is in flight.
module serial_frame_tx #(
    parameter int          PREAMBLE_BYTES = 4,
    parameter logic [15:0] SYNC_WORD      = 16'hF628,
    parameter int          LEN_W          = 16,
    parameter int          TAIL_BITS      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             bit_tick,
    output logic             tick_en,
    output logic             tx_bit,
    output logic             tx_active,
    output logic             done,
    output logic             underrun
);

    localparam logic [7:0] PRE_BYTE  = 8'h55;
    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_BYTES * 8 - 1);
    localparam logic [7:0] SYNC_LAST = 8'd15;
    localparam logic [7:0] BYTE_LAST = 8'd7;
    localparam logic [7:0] TAIL_LAST = 8'(TAIL_BITS - 1);

    typedef enum logic [2:0] {IDLE, PRE, SYNC, PAY, TAIL} state_t;

    state_t           r_state;
    logic [14:0]      r_sr;        // bits still to follow the one on the line
    logic [7:0]       r_bit_cnt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_sent;
    logic [LEN_W-1:0] r_fetched;
    logic [7:0]       r_buf;
    logic             r_buf_full;
    logic             r_tx_bit;
    logic             r_tx_active;
    logic             r_tick_en;
    logic             r_done;
    logic             r_underrun;

    logic             w_s_ready;
    logic             w_accept;
    logic             w_load;
    logic             w_underrun_load;
    logic [7:0]       w_load_byte;

    assign w_s_ready = !r_buf_full && (r_fetched < r_len) && (r_state != IDLE);
    assign w_accept  = s_valid && w_s_ready;

    assign w_load = bit_tick &&
                    (((r_state == SYNC) && (r_bit_cnt == SYNC_LAST) && (r_len != '0)) ||
                     ((r_state == PAY)  && (r_bit_cnt == BYTE_LAST) && (r_sent != r_len)));
    assign w_underrun_load = w_load && !r_buf_full;
    assign w_load_byte     = r_buf_full ? r_buf : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_len       <= '0;
            r_sent      <= '0;
            r_fetched   <= '0;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_tx_bit    <= 1'b0;
            r_tx_active <= 1'b0;
            r_tick_en   <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A same-cycle accept refills the slot that a load is emptying.
            if (w_accept) begin
                r_buf      <= s_data;
                r_buf_full <= 1'b1;
            end else if (w_load) begin
                r_buf_full <= 1'b0;
            end

            // An underrun byte consumes one fetch slot; a concurrent accept covers the same slot.
            if (w_accept || w_underrun_load) begin
                r_fetched <= r_fetched + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    // done still high means the previous frame closed on this very edge
                    if (start && !r_done) begin
                        r_state     <= PRE;
                        r_len       <= frame_len;
                        r_underrun  <= 1'b0;
                        r_tx_bit    <= PRE_BYTE[7];
                        r_sr        <= {PRE_BYTE[6:0], 8'h00};
                        r_tx_active <= 1'b1;
                        r_tick_en   <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_sent      <= '0;
                        r_fetched   <= '0;
                        r_buf_full  <= 1'b0;
                    end
                end
                PRE: begin
                    if (bit_tick) begin
                        if (r_bit_cnt == PRE_LAST) begin
                            r_state   <= SYNC;
                            r_tx_bit  <= SYNC_WORD[15];
                            r_sr      <= SYNC_WORD[14:0];
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                            if (r_bit_cnt[2:0] == 3'd7) begin
                                r_tx_bit <= PRE_BYTE[7];
                                r_sr     <= {PRE_BYTE[6:0], 8'h00};
                            end else begin
                                r_tx_bit <= r_sr[14];
                                r_sr     <= {r_sr[13:0], 1'b0};
                            end
                        end
                    end
                end
                SYNC, PAY: begin
                    if (bit_tick) begin
                        if (w_load) begin
                            r_state    <= PAY;
                            r_tx_bit   <= w_load_byte[7];
                            r_sr       <= {w_load_byte[6:0], 8'h00};
                            r_bit_cnt  <= '0;
                            r_sent     <= r_sent + 1'b1;
                            if (!r_buf_full) begin
                                r_underrun <= 1'b1;
                            end
                        end else if (((r_state == SYNC) && (r_bit_cnt == SYNC_LAST)) ||
                                     ((r_state == PAY)  && (r_bit_cnt == BYTE_LAST))) begin
                            r_state   <= TAIL;
                            r_tx_bit  <= 1'b0;
                            r_sr      <= '0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_tx_bit  <= r_sr[14];
                            r_sr      <= {r_sr[13:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                end
                TAIL: begin
                    if (bit_tick) begin
                        if (r_bit_cnt == TAIL_LAST) begin
                            r_state     <= IDLE;
                            r_tx_bit    <= 1'b0;
                            r_tx_active <= 1'b0;
                            r_tick_en   <= 1'b0;
                            r_done      <= 1'b1;
                            r_bit_cnt   <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready   = w_s_ready;
    assign tick_en   = r_tick_en;
    assign tx_bit    = r_tx_bit;
    assign tx_active = r_tx_active;
    assign done      = r_done;
    assign underrun  = r_underrun;

endmodule
